// File: rtl/approx_mac_accum_pkg.sv
// Shared types and defaults for the approximate multiply-accumulate slice.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_ACC_W       = 20;
  localparam int unsigned DEF_APPROX_BITS = 4;
  localparam int unsigned DEF_LEN         = 16;

  // Bits needed to hold a term count from 0 up to and including len.
  function automatic int unsigned count_w(input int unsigned len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/approx_mac_accum_loa_adder.sv
// Lower-part-OR adder: OR gates in the low APPROX_BITS, exact ripple above.
module loa_adder #(
  parameter int unsigned ACC_W       = 20,
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic [ACC_W-1:0] x,
  input  logic [ACC_W-1:0] y,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);

  logic [ACC_W:APPROX_BITS] c;

  if (APPROX_BITS > 0) begin : g_lo
    assign sum[APPROX_BITS-1:0] = x[APPROX_BITS-1:0] | y[APPROX_BITS-1:0];
    // Carry into the exact part is guessed from the top approximate bit pair.
    assign c[APPROX_BITS] = x[APPROX_BITS-1] & y[APPROX_BITS-1];
  end else begin : g_exact
    assign c[APPROX_BITS] = 1'b0;
  end

  for (genvar i = APPROX_BITS; i < ACC_W; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[ACC_W];

endmodule

// File: rtl/approx_mac_accum.sv
// Streams operand pairs in, accumulates LEN approximate products, emits one result.
module approx_mac_accum
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned ACC_W       = DEF_ACC_W,
  parameter int unsigned APPROX_BITS = DEF_APPROX_BITS,
  parameter int unsigned LEN         = DEF_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int unsigned CW = count_w(LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [2*WIDTH-1:0] prod;
  logic [ACC_W-1:0]   p_ext;
  logic [ACC_W-1:0]   sum;
  logic               cout;
  logic               take;
  logic               give;

  assign prod  = a * b;
  assign p_ext = ACC_W'(prod);
  assign take  = in_valid & in_ready;
  assign give  = out_valid & out_ready;

  loa_adder #(
    .ACC_W       (ACC_W),
    .APPROX_BITS (APPROX_BITS)
  ) u_loa (
    .x    (acc),
    .y    (p_ext),
    .sum  (sum),
    .cout (cout)
  );

  // FSM, term counter, accumulator and registered handshake/result outputs.
  // IDLE and ACC share one transfer path: acc/ovf are already 0 in IDLE,
  // and the last-term test count==LEN-1 also covers LEN==1 from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (take) begin
            acc   <= sum;
            ovf   <= ovf | cout;
            count <= count + 1'b1;
            if (count == LAST_IDX) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_acc   <= sum;
              out_ovf   <= ovf | cout;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (give) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          acc       <= '0;
          ovf       <= 1'b0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_acc   <= '0;
          out_ovf   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mac_accum.sv
// Scoreboard bench for approx_mac_accum across four parameter configurations.
module tb_approx_mac_accum;

  // 0: defaults, 1: LEN=4 APPROX=4, 2: LEN=4 exact, 3: ACC_W=16 LEN=4 APPROX=4
  localparam int unsigned ND = 4;

  typedef struct {
    int unsigned d;
    logic [19:0] acc;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst       [ND];
  logic        in_valid  [ND];
  logic        in_ready  [ND];
  logic [7:0]  a         [ND];
  logic [7:0]  b         [ND];
  logic        out_valid [ND];
  logic        out_ready [ND];
  logic [19:0] out_acc   [ND];
  logic        out_ovf   [ND];
  logic [15:0] acc16;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  approx_mac_accum u_def (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_acc(out_acc[0]), .out_ovf(out_ovf[0])
  );

  approx_mac_accum #(.WIDTH(8), .ACC_W(20), .APPROX_BITS(4), .LEN(4)) u_apx (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_acc(out_acc[1]), .out_ovf(out_ovf[1])
  );

  approx_mac_accum #(.WIDTH(8), .ACC_W(20), .APPROX_BITS(0), .LEN(4)) u_exa (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_acc(out_acc[2]), .out_ovf(out_ovf[2])
  );

  approx_mac_accum #(.WIDTH(8), .ACC_W(16), .APPROX_BITS(4), .LEN(4)) u_wrp (
    .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .a(a[3]), .b(b[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_acc(acc16), .out_ovf(out_ovf[3])
  );

  assign out_acc[3] = {4'b0000, acc16};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int unsigned d, input logic [19:0] acc, input logic ovf);
    exp_t e;
    e.d = d; e.acc = acc; e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Offer one pair; returns just after the accepting edge.
  task automatic send(input int unsigned d, input logic [7:0] x, input logic [7:0] y);
    int unsigned w;
    w = 0;
    @(negedge clk);
    in_valid[d] = 1'b1; a[d] = x; b[d] = y;
    while (!in_ready[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready[d]) check("send_ready_timeout", 32'(in_ready[d]), 32'd1);
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  // Idle cycles with junk operands on the bus and in_valid low.
  task automatic gap(input int unsigned d, input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      in_valid[d] = 1'b0; a[d] = 8'hA5; b[d] = 8'h5A;
    end
  endtask

  task automatic recv(input int unsigned d);
    exp_t e;
    int unsigned w;
    w = 0;
    @(negedge clk);
    out_ready[d] = 1'b1;
    while (!out_valid[d] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("out_valid", 32'(out_valid[d]), 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("sb_dut", d, e.d);
      check("out_acc", 32'(out_acc[d]), 32'(e.acc));
      check("out_ovf", 32'(out_ovf[d]), 32'(e.ovf));
    end
    @(posedge clk);
    #1 out_ready[d] = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready[d]), 32'd1);
    check("idle_out_valid", 32'(out_valid[d]), 32'd0);
    check("idle_out_acc", 32'(out_acc[d]), 32'd0);
  endtask

  task automatic round4(input int unsigned d, input logic [7:0] x, input logic [7:0] y);
    for (int i = 0; i < 4; i++) send(d, x, y);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(ND); i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      a[i] = '0; b[i] = '0;
    end

    // Reset with in_valid asserted on the default instance.
    in_valid[0] = 1'b1; a[0] = 8'd4; b[0] = 8'd4;
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready[0]), 32'd1);
      check("rst_out_valid", 32'(out_valid[0]), 32'd0);
      check("rst_out_acc", 32'(out_acc[0]), 32'd0);
      check("rst_out_ovf", 32'(out_ovf[0]), 32'd0);
    end
    for (int i = 0; i < int'(ND); i++) rst[i] = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid[0]), 32'd0);

    // Defaults: 16 terms of 16 land fully in the exact part -> 0x100.
    push(0, 20'h00100, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send(0, 8'd4, 8'd4);
      if (i == 14) check("def_not_done_at_15", 32'(out_valid[0]), 32'd0);
    end
    recv(0);

    // Approximation: 1+1+1+1 ORs down to 1; result one cycle after 4th term.
    push(1, 20'h00001, 1'b0);
    round4(1, 8'd1, 8'd1);
    @(negedge clk);
    check("apx_latency", 32'(out_valid[1]), 32'd1);
    recv(1);

    // Backpressure: result holds, inputs ignored.
    push(1, 20'h00001, 1'b0);
    round4(1, 8'd1, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[1] = 1'b1; a[1] = 8'd7; b[1] = 8'd7;
      check("bp_out_valid", 32'(out_valid[1]), 32'd1);
      check("bp_out_acc", 32'(out_acc[1]), 32'd1);
      check("bp_in_ready", 32'(in_ready[1]), 32'd0);
    end
    in_valid[1] = 1'b0;
    recv(1);
    push(1, 20'h00001, 1'b0);
    round4(1, 8'd1, 8'd1);
    recv(1);

    // Exact path.
    push(2, 20'h00004, 1'b0);
    round4(2, 8'd1, 8'd1);
    recv(2);
    push(2, 20'h00040, 1'b0);
    round4(2, 8'd4, 8'd4);
    recv(2);

    // Mid-operation reset then stalled input stream: 4*4 = 16.
    send(2, 8'd3, 8'd3);
    send(2, 8'd3, 8'd3);
    @(negedge clk);
    rst[2] = 1'b1;
    @(posedge clk);
    #1 rst[2] = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready[2]), 32'd1);
    check("midrst_out_valid", 32'(out_valid[2]), 32'd0);
    push(2, 20'h00010, 1'b0);
    send(2, 8'd2, 8'd2);
    gap(2, 2);
    send(2, 8'd2, 8'd2);
    gap(2, 3);
    send(2, 8'd2, 8'd2);
    gap(2, 2);
    check("gap_no_early_done", 32'(out_valid[2]), 32'd0);
    send(2, 8'd2, 8'd2);
    recv(2);

    // Wrap: 4 x 0xFE01 in 16 bits -> 0xF801 with sticky overflow.
    push(3, 20'h0F801, 1'b1);
    round4(3, 8'd255, 8'd255);
    recv(3);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
